// File: rtl/bus_slave_port.sv
// bus_slave_port: serial slave endpoint on the downstream side of the
// two-master system bus. It deserialises request frames (mode, address,
// burst) and then either writes payload bytes into local synchronous memory
// or streams stored bytes back to the bus, MSB first.
//
// Optional feature: define BUS_SLAVE_PARITY_EN to expect one even-parity bit
// after every write data byte. A byte with bad parity is not written, but the
// address still advances and err is raised until the next frame start.
// When the macro is not defined, err is tied low.
module bus_slave_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int BURST_W = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_bit,
  input  logic rx_valid,
  output logic tx_bit,
  output logic tx_valid,
  output logic ready,
  output logic done,
  output logic err
);

  localparam int HDR_W = ADDR_W + BURST_W;
  localparam int HCW   = $clog2(HDR_W + 1);

`ifdef BUS_SLAVE_PARITY_EN
  localparam int BYTE_BITS = DATA_W + 1;
  localparam int WSH_W     = DATA_W;
`else
  localparam int BYTE_BITS = DATA_W;
  localparam int WSH_W     = DATA_W - 1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RFETCH,
    RDATA,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic               mode;
  logic [HDR_W-2:0]   hdr_sh;
  logic [HDR_W-1:0]   hdr_full;
  logic [HCW-1:0]     hdr_cnt;
  logic [ADDR_W-1:0]  addr;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] byte_cnt;
  logic [3:0]         bit_cnt;
  logic [WSH_W-1:0]   wsh;
  logic [DATA_W-1:0]  wbyte;
  logic [DATA_W-1:0]  tx_sh;
  logic               par_ok;

  logic hdr_last;
  logic byte_last_bit;
  logic wr_last;
  logic rd_byte_end;
  logic rd_last;
  logic we;
  logic rd_en;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // The incoming bit is appended combinationally so the last header bit can
  // be decoded on the same edge that samples it.
  assign hdr_full = {hdr_sh, rx_bit};

`ifdef BUS_SLAVE_PARITY_EN
  // The parity bit arrives after the full byte has been shifted in.
  assign wbyte  = wsh;
  assign par_ok = ((^wsh) == rx_bit);
`else
  // Byte completes on its 8th bit, so only 7 bits need to be held.
  assign wbyte  = {wsh, rx_bit};
  assign par_ok = 1'b1;
`endif

  assign hdr_last      = (state == HDR) && rx_valid && (hdr_cnt == HCW'(HDR_W - 1));
  assign byte_last_bit = (state == WDATA) && rx_valid && (bit_cnt == 4'(BYTE_BITS - 1));
  assign wr_last       = byte_last_bit && (byte_cnt == burst);
  assign rd_byte_end   = (state == RDATA) && (bit_cnt == 4'(DATA_W - 1));
  assign rd_last       = rd_byte_end && (byte_cnt == burst);
  assign we            = byte_last_bit && par_ok;
  // The next byte is fetched during the last bit of the current one so the
  // outgoing stream has no gaps between bytes.
  assign rd_en         = (state == RFETCH) || rd_byte_end;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    tx_valid  = 1'b0;
    tx_bit    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (rx_valid) state_nxt = HDR;
      end
      HDR: begin
        if (hdr_last) state_nxt = mode ? WDATA : RFETCH;
      end
      WDATA: begin
        if (wr_last) state_nxt = DONE;
      end
      RFETCH: begin
        state_nxt = RDATA;
      end
      RDATA: begin
        tx_valid = 1'b1;
        tx_bit   = tx_sh[DATA_W-1];
        if (rd_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: header capture, address and burst counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode     <= 1'b0;
      hdr_sh   <= '0;
      hdr_cnt  <= '0;
      addr     <= '0;
      burst    <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      wsh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            mode     <= rx_bit;
            hdr_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        HDR: begin
          if (rx_valid) begin
            hdr_sh  <= hdr_full[HDR_W-2:0];
            hdr_cnt <= hdr_cnt + HCW'(1);
            if (hdr_last) begin
              addr     <= hdr_full[HDR_W-1:BURST_W];
              burst    <= hdr_full[BURST_W-1:0];
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end
          end
        end
        WDATA: begin
          if (rx_valid) begin
            wsh <= {wsh[WSH_W-2:0], rx_bit};
            if (byte_last_bit) begin
              bit_cnt  <= '0;
              addr     <= addr + ADDR_W'(1);
              byte_cnt <= byte_cnt + BURST_W'(1);
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        RFETCH: begin
          addr     <= addr + ADDR_W'(1);
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
        RDATA: begin
          if (rd_byte_end) begin
            bit_cnt  <= '0;
            addr     <= addr + ADDR_W'(1);
            byte_cnt <= byte_cnt + BURST_W'(1);
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Local memory and read shifter; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wbyte;
    if (rd_en) tx_sh <= mem[addr];
    else       tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
  end

`ifdef BUS_SLAVE_PARITY_EN
  logic err_q;

  // Sticky parity error, cleared when the next frame starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           err_q <= 1'b0;
    else if ((state == IDLE) && rx_valid) err_q <= 1'b0;
    else if (byte_last_bit && !par_ok)   err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: directed bench for bus_slave_port. Inputs change 1 ns
// after each rising edge and outputs are sampled at that same point.
// Define BUS_SLAVE_PARITY_EN for both files to exercise the parity build.
module tb_bus_slave_port;

`ifdef BUS_SLAVE_PARITY_EN
  localparam int BPB = 9;
`else
  localparam int BPB = 8;
`endif

  logic clk;
  logic reset;
  logic rx_bit;
  logic rx_valid;
  logic tx_bit;
  logic tx_valid;
  logic ready;
  logic done;
  logic err;

  int errors;
  int checks;
  int cyc;

  logic [7:0] wq[$];
  logic [7:0] expq[$];

  bus_slave_port #(.ADDR_W(12), .DATA_W(8), .BURST_W(13)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_bit   (rx_bit),
    .rx_valid (rx_valid),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .ready    (ready),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_bit   = v[n-1-i];
      tick();
    end
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  // Full write frame from wq, checking ready drop, done timing and return.
  task automatic write_frame(input logic [11:0] a, input logic [12:0] b);
    int t0;
    t0 = cyc;
    send_bits(32'd1, 1);
    check("wr_ready_drop", 32'(ready), 32'd0);
    send_bits(32'({a, b}), 25);
    for (int unsigned k = 0; k < wq.size(); k++) begin
      send_bits(32'(wq[k]), 8);
`ifdef BUS_SLAVE_PARITY_EN
      send_bits(32'(^wq[k]), 1);
`endif
    end
    check("wr_done", 32'(done), 32'd1);
    check("wr_cycles", 32'(cyc - t0), 32'(26 + BPB * (int'(b) + 1)));
    idle_cycle();
    check("wr_done_pulse", 32'(done), 32'd0);
    check("wr_ready_back", 32'(ready), 32'd1);
  endtask

  // Full read frame, comparing the serial stream against expq.
  task automatic read_frame(input logic [11:0] a, input logic [12:0] b);
    int nvalid;
    logic [7:0] got;
    send_bits(32'd0, 1);
    send_bits(32'({a, b}), 25);
    check("rd_fetch_txv", 32'(tx_valid), 32'd0);
    check("rd_fetch_txb", 32'(tx_bit), 32'd0);
    tick();
    nvalid = 0;
    for (int unsigned k = 0; k < expq.size(); k++) begin
      got = '0;
      for (int unsigned j = 0; j < 8; j++) begin
        if (tx_valid) nvalid++;
        got = {got[6:0], tx_bit};
        tick();
      end
      check("rd_byte", 32'(got), 32'(expq[k]));
    end
    check("rd_len", 32'(nvalid), 32'(8 * (int'(b) + 1)));
    check("rd_done", 32'(done), 32'd1);
    check("rd_txv_off", 32'(tx_valid), 32'd0);
    idle_cycle();
    check("rd_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    logic [24:0] hv;
    int t0;
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    rx_bit   = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txb", 32'(tx_bit), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    idle_cycle();
    check("idle_ready", 32'(ready), 32'd1);

    // Single-byte write and read back: 0xBD streams as 1,0,1,1,1,1,0,1.
    wq = '{8'hBD};
    write_frame(12'hA95, 13'd0);
    expq = '{8'hBD};
    read_frame(12'hA95, 13'd0);

    // Burst crossing the top of memory wraps to address 0.
    wq = '{8'h11, 8'h22, 8'h33};
    write_frame(12'hFFF, 13'd2);
    expq = '{8'h11, 8'h22, 8'h33};
    read_frame(12'hFFF, 13'd2);
    expq = '{8'h22};
    read_frame(12'h000, 13'd0);

    // Stalls of 3 cycles mid-header and 2 cycles mid-byte.
    hv = {12'h010, 13'd0};
    t0 = cyc;
    send_bits(32'd1, 1);
    send_bits(32'(hv[24:15]), 10);
    repeat (3) idle_cycle();
    check("stall_hdr_ready", 32'(ready), 32'd0);
    send_bits(32'(hv[14:0]), 15);
    send_bits(32'h5, 4);
    repeat (2) idle_cycle();
    check("stall_byte_done", 32'(done), 32'd0);
    send_bits(32'hA, 4);
`ifdef BUS_SLAVE_PARITY_EN
    send_bits(32'd0, 1);
`endif
    check("stall_done", 32'(done), 32'd1);
    check("stall_cycles", 32'(cyc - t0), 32'(26 + BPB + 5));
    idle_cycle();
    expq = '{8'h5A};
    read_frame(12'h010, 13'd0);

    // Reset during byte 2 of a burst write: byte 1 kept, byte 2 discarded.
    wq = '{8'h77};
    write_frame(12'h101, 13'd0);
    send_bits(32'd1, 1);
    send_bits(32'({12'h100, 13'd3}), 25);
    send_bits(32'hAA, 8);
`ifdef BUS_SLAVE_PARITY_EN
    send_bits(32'd0, 1);
`endif
    send_bits(32'hB, 4);
    reset = 1'b1;
    #1;
    check("wrst_ready", 32'(ready), 32'd1);
    check("wrst_done", 32'(done), 32'd0);
    check("wrst_txv", 32'(tx_valid), 32'd0);
    check("wrst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expq = '{8'hAA, 8'h77};
    read_frame(12'h100, 13'd1);

    // Reset in the middle of a read stream drops tx_valid at once.
    send_bits(32'd0, 1);
    send_bits(32'({12'hA95, 13'd0}), 25);
    repeat (4) tick();
    check("rrst_txv_before", 32'(tx_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rrst_txv", 32'(tx_valid), 32'd0);
    check("rrst_txb", 32'(tx_bit), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expq = '{8'hBD};
    read_frame(12'hA95, 13'd0);

`ifdef BUS_SLAVE_PARITY_EN
    // Bad parity: byte dropped, err sticky until the next frame start.
    wq = '{8'h33};
    write_frame(12'h200, 13'd0);
    send_bits(32'd1, 1);
    send_bits(32'({12'h200, 13'd0}), 25);
    send_bits(32'h0F, 8);
    send_bits(32'd1, 1);
    check("par_bad_done", 32'(done), 32'd1);
    check("par_bad_err", 32'(err), 32'd1);
    repeat (3) idle_cycle();
    check("par_err_hold", 32'(err), 32'd1);
    send_bits(32'd0, 1);
    check("par_err_clear", 32'(err), 32'd0);
    send_bits(32'({12'h200, 13'd0}), 25);
    repeat (11) tick();
    expq = '{8'h33};
    read_frame(12'h200, 13'd0);
    wq = '{8'h0F};
    write_frame(12'h200, 13'd0);
    check("par_good_err", 32'(err), 32'd0);
    expq = '{8'h0F};
    read_frame(12'h200, 13'd0);
`endif

    check("final_err", 32'(err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
